// File: rtl/tx_pkg.sv
// tx_pkg: shared state encoding, frame constants and channel tags for the tx arbiter
package tx_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    ACK_HDR = 3'd2,
    LO      = 3'd3,
    ACK_LO  = 3'd4
  } state_e;
  localparam int SYNC_BIT = 7;
  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;
  localparam int ACK_TIMEOUT_DEF = 16;
endpackage

// File: rtl/tx_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-request round-robin grant with a registered last-served pointer
module rr_arbiter2
  import tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served,
  output logic [1:0] o_grant
);
  logic last_q, last_d;
  // on contention favour the channel not served last; a lone request always wins
  always_comb begin
    o_grant = (&i_req) ? (last_q == CH2 ? 2'b01 : 2'b10) : i_req;
    last_d = i_update ? i_served : last_q;
  end
  // pointer starts at ch2 so ch1 wins the first contention
  always_ff @(posedge clk) begin
    last_q <= rst ? CH2 : last_d;
  end
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one tx_unit between two gate buffers, framing each sample as hdr/lo bytes
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int DATA_SIZE    = 14,
  parameter int TX_DATA_SIZE = 8,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [1:0]              i_ch_mask,
  input  logic                    i_valid_ch1,
  input  logic [DATA_SIZE-1:0]    i_data_ch1,
  output logic                    o_next_ch1,
  input  logic                    i_valid_ch2,
  input  logic [DATA_SIZE-1:0]    i_data_ch2,
  output logic                    o_next_ch2,
  input  logic                    i_txready,
  output logic                    o_send,
  output logic [TX_DATA_SIZE-1:0] o_txdata,
  output logic                    o_busy,
  output logic                    o_tx_error
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_e               state_q, state_d;
  logic                 ch_q, ch_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [1:0]           req, grant;
  logic                 pop, send, update;
  logic [TX_DATA_SIZE-1:0] hdr, lo;
  assign req = {i_valid_ch2 & i_ch_mask[1], i_valid_ch1 & i_ch_mask[0]} & {2{i_enable}};
  rr_arbiter2 u_rr (
    .clk      (i_clock),
    .rst      (i_reset),
    .i_req    (req),
    .i_update (update),
    .i_served (ch_q),
    .o_grant  (grant)
  );
  // frame sequencing: grant/pop, then send each byte and wait for tx_unit to take it
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    data_d = data_q;
    cnt_d = cnt_q;
    err_d = err_q;
    pop = 1'b0;
    send = 1'b0;
    update = 1'b0;
    case (state_q)
      IDLE: if (|grant) begin
        pop = 1'b1;
        ch_d = grant[1];
        data_d = grant[1] ? i_data_ch2 : i_data_ch1;
        state_d = HDR;
      end
      HDR, LO: if (i_txready) begin
        send = 1'b1;
        cnt_d = '0;
        state_d = state_q == HDR ? ACK_HDR : ACK_LO;
      end
      ACK_HDR, ACK_LO: if (!i_txready) begin
        update = state_q == ACK_LO;
        state_d = state_q == ACK_HDR ? LO : IDLE;
      end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
        err_d = 1'b1;
        state_d = state_q == ACK_HDR ? HDR : LO;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // byte images of the latched sample; data[0] does not fit and is dropped
  always_comb begin
    hdr = {1'b1, ch_q, data_q[DATA_SIZE-1 -: TX_DATA_SIZE-2]};
    lo = {1'b0, data_q[TX_DATA_SIZE-1:1]};
    o_txdata = (state_q == HDR || state_q == ACK_HDR) ? hdr :
               (state_q == LO || state_q == ACK_LO) ? lo : '0;
    o_next_ch1 = pop & grant[0] & ~i_reset;
    o_next_ch2 = pop & grant[1] & ~i_reset;
    o_send = send & ~i_reset;
    o_busy = state_q != IDLE;
    o_tx_error = err_q;
  end
  // state registers; reset abandons any frame in flight
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      ch_q <= CH1;
      data_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter with a buffer and tx_unit model
module tb_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, txready = 1'b1, stuck = 1'b0;
  logic [1:0] mask = 2'b11;
  logic [13:0] d1 = '0, d2 = '0;
  logic valid1, valid2, next1, next2, send, busy, err;
  logic [7:0] txdata;
  int allow1 = 0, allow2 = 0, pops1 = 0, pops2 = 0, busy_cnt = 0, overlap = 0;
  int checks = 0, failures = 0, n;
  logic [7:0] bytes[$];
  int pops[$];
  assign valid1 = pops1 < allow1;
  assign valid2 = pops2 < allow2;
  always #5 clk = ~clk;
  tx_arbiter dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_ch_mask   (mask),
    .i_valid_ch1 (valid1),
    .i_data_ch1  (d1),
    .o_next_ch1  (next1),
    .i_valid_ch2 (valid2),
    .i_data_ch2  (d2),
    .o_next_ch2  (next2),
    .i_txready   (txready),
    .o_send      (send),
    .o_txdata    (txdata),
    .o_busy      (busy),
    .o_tx_error  (err)
  );
  // tx_unit model: busy for 3 cycles after each send unless stuck; buffers pop on o_next
  always @(posedge clk) begin
    if (send) begin
      bytes.push_back(txdata);
      if (!stuck) begin
        txready <= 1'b0;
        busy_cnt <= 3;
      end
    end else if (busy_cnt == 1) begin
      txready <= 1'b1;
      busy_cnt <= 0;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (next1) begin
      pops1 <= pops1 + 1;
      pops.push_back(1);
    end
    if (next2) begin
      pops2 <= pops2 + 1;
      pops.push_back(2);
    end
    if (next1 && next2) overlap <= overlap + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_bytes(input int k, input string tag);
    for (int i = 0; i < 400 && bytes.size() < k; i++) cyc(1);
    chk(tag, 32'(bytes.size() >= k), 1);
  endtask
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) cyc(1);
    chk(tag, 32'(busy), 0);
  endtask
  task automatic clear();
    bytes.delete();
    pops.delete();
  endtask
  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_send", 32'(send), 0);
    chk("rst_txdata", 32'(txdata), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_next", 32'({next2, next1}), 0);
    // ch1 only
    d1 = 14'h2A5F;
    clear();
    allow1 = 1;
    wait_bytes(2, "ch1_bytes_wait");
    wait_idle("ch1_idle");
    cyc(5);
    chk("ch1_pop_count", 32'(pops.size()), 1);
    chk("ch1_pop_ch", 32'(pops[0]), 1);
    chk("ch1_hdr", 32'(bytes[0]), 32'hAA);
    chk("ch1_lo", 32'(bytes[1]), 32'h2F);
    chk("ch1_err", 32'(err), 0);
    // both channels contending, fresh pointer
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    d2 = 14'h1FFF;
    clear();
    allow1 += 2;
    allow2 += 2;
    wait_bytes(8, "alt_bytes_wait");
    wait_idle("alt_idle");
    cyc(3);
    chk("alt_pop_count", 32'(pops.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_pop%0d", i), 32'(pops[i]), (i % 2) ? 2 : 1);
    chk("alt_ch1_hdr", 32'(bytes[0]), 32'hAA);
    chk("alt_ch2_hdr", 32'(bytes[2]), 32'hDF);
    chk("alt_ch2_lo", 32'(bytes[3]), 32'h7F);
    chk("alt_ch2_hdr2", 32'(bytes[6]), 32'hDF);
    chk("alt_overlap", 32'(overlap), 0);
    // mask keeps only ch2
    mask = 2'b10;
    clear();
    allow1 += 1;
    allow2 += 1;
    wait_bytes(2, "mask_bytes_wait");
    wait_idle("mask_idle");
    cyc(3);
    chk("mask_pop_count", 32'(pops.size()), 1);
    chk("mask_pop_ch", 32'(pops[0]), 2);
    chk("mask_hdr", 32'(bytes[0]), 32'hDF);
    // disabled: ch1 still pending but nothing may happen
    en = 1'b0;
    mask = 2'b11;
    clear();
    cyc(100);
    chk("dis_pops", 32'(pops.size()), 0);
    chk("dis_sends", 32'(bytes.size()), 0);
    chk("dis_busy", 32'(busy), 0);
    allow1 = pops1;
    en = 1'b1;
    // ack timeout then recovery
    stuck = 1'b1;
    clear();
    d1 = 14'h2A5F;
    allow1 += 1;
    wait_bytes(1, "to_first_send");
    n = 0;
    while (err !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("to_cycles", 32'(n), 16);
    chk("to_resend", 32'(send), 1);
    chk("to_resend_data", 32'(txdata), 32'hAA);
    stuck = 1'b0;
    wait_bytes(3, "to_bytes_wait");
    wait_idle("to_idle");
    chk("to_retry_hdr", 32'(bytes[1]), 32'hAA);
    chk("to_lo", 32'(bytes[2]), 32'h2F);
    chk("to_sticky", 32'(err), 1);
    chk("to_single_pop", 32'(pops.size()), 1);
    // reset while in ACK_LO
    cyc(5);
    clear();
    allow1 += 1;
    wait_bytes(2, "ra_bytes_wait");
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("ra_busy", 32'(busy), 0);
    chk("ra_send", 32'(send), 0);
    chk("ra_txdata", 32'(txdata), 0);
    chk("ra_err", 32'(err), 0);
    clear();
    allow1 += 1;
    allow2 += 1;
    for (int i = 0; i < 50 && pops.size() < 1; i++) cyc(1);
    chk("ra_grant_seen", 32'(pops.size() >= 1), 1);
    chk("ra_grant_ch1", 32'(pops[0]), 1);
    wait_bytes(4, "ra_bytes_done");
    wait_idle("ra_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares one tx_unit serial link between the ch1 and ch2 gate_buffer outputs.
- Pops samples from each buffer with round-robin fairness and frames each sample as two bytes tagged with the channel.
- Drives the tx_unit send/ready handshake.
- Sits between the gate buffers and a single tx_unit on sys_clock, replacing the per-channel tx_unit pair.

Parameters:
- DATA_SIZE, 14, width of gate_buffer sample. Fixed relation: DATA_SIZE = 2*TX_DATA_SIZE-2.
- TX_DATA_SIZE, 8, width of a tx_unit byte.
- ACK_TIMEOUT, 16, cycles to wait for i_txready to drop after a send before retrying.

Ports:
- i_clock  in  1  sys_clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  arbitration enable (tie to adc_init_done)
- i_ch_mask  in  2  per-channel enable; bit0=ch1, bit1=ch2
- i_valid_ch1  in  1  ch1 buffer has a sample
- i_data_ch1  in  DATA_SIZE  ch1 sample
- o_next_ch1  out  1  one-cycle pop pulse to ch1 buffer
- i_valid_ch2  in  1  ch2 buffer has a sample
- i_data_ch2  in  DATA_SIZE  ch2 sample
- o_next_ch2  out  1  one-cycle pop pulse to ch2 buffer
- i_txready  in  1  tx_unit idle
- o_send  out  1  one-cycle send strobe to tx_unit
- o_txdata  out  TX_DATA_SIZE  byte to tx_unit
- o_busy  out  1  frame in progress (state != IDLE)
- o_tx_error  out  1  sticky; set on any ACK timeout

Behaviour:
- Reset: state=IDLE, rr_last=ch2 (so ch1 wins first), all outputs 0, latched sample 0, timeout counter 0.
- Reset mid-frame aborts immediately; the popped sample is lost.
- Frame format (14/8):
  - hdr = {1'b1, ch, data[13:8]}, ch: 0=ch1, 1=ch2.
  - lo = {1'b0, data[7:1]}; data[0] is dropped.
  - Bit7 is the sync flag.
- IDLE:
  - eligible_x = i_valid_x & i_ch_mask[x] & i_enable.
  - If both are eligible, grant the channel != rr_last. If one is eligible, grant it.
  - On grant in cycle N: o_next_x=1 in cycle N only; latch i_data_x and ch in cycle N; go to HDR in N+1.
- HDR:
  - o_txdata=hdr, held.
  - On the first cycle with i_txready=1: o_send=1 for that cycle, go to ACK_HDR, clear timeout counter.
- ACK_HDR:
  - i_txready=0 -> LO.
  - Else count. When the counter reaches ACK_TIMEOUT-1: set o_tx_error, return to HDR (retry).
- LO: as HDR with o_txdata=lo, then go to ACK_LO.
- ACK_LO: as ACK_HDR. On drop, rr_last=served channel and go to IDLE. On timeout, set o_tx_error and return to LO.
- o_txdata holds its value from HDR entry until the next state change that alters it; it is 0 in IDLE.
- Minimum frame cost: 1 (IDLE grant) + 2×(send + ≥1 ack) cycles, plus tx_unit byte time.
- Boundaries:
  - i_enable or mask drop mid-frame: the frame completes; no new grant.
  - Valid drops in the grant cycle: the grant already issued stands; the buffer must honour the pop or ignore it.
  - Back-to-back: a new grant is allowed in the first IDLE cycle after ACK_LO.
  - o_next pulses never overlap and never exceed one per frame.

Decomposition:
- Shared package tx_pkg:
  - state encoding localparams (IDLE, HDR, ACK_HDR, LO, ACK_LO)
  - SYNC_BIT position
  - CH1/CH2 tag values
  - default ACK_TIMEOUT
- One natural sub-module, rr_arbiter2: two-request round-robin grant with last-served pointer, combinational grant plus registered pointer update on i_update.

Test Plan:
- ch1-only: i_valid_ch1=1, data=14'h2A5F, mask=2'b11, tx model ready after 3 cycles -> one o_next_ch1 pulse; bytes 8'hAA then 8'h2F.
- Both channels continuously valid, ch2 data=14'h1FFF -> grants alternate ch1,ch2,ch1,ch2; ch2 header = 8'hDF; no double pops.
- Mask=2'b10 with both valid -> only ch2 is served.
- i_enable=0 -> no o_next and no o_send in 100 cycles.
- Timeout: tx model keeps i_txready=1 after the send -> after 16 cycles o_tx_error=1 and hdr is re-sent; the model then drops ready -> the frame completes; error stays sticky.
- Reset in ACK_LO -> next cycle: IDLE, o_send=0, o_busy=0, o_txdata=0; the following grant goes to ch1.
